// File: rtl/pipe_pack.sv
// Packs PACK_NUM narrow beats from the middle stage into one registered wide word
// with a per-lane keep mask; last_middle closes a partial word early.
module pipe_pack #(
  parameter int unsigned DATA_W   = 3,
  parameter int unsigned PACK_NUM = 4
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       valid_middle,
  input  logic [DATA_W-1:0]          data_middle,
  input  logic                       last_middle,
  output logic                       ready_middle,
  output logic                       valid_down,
  output logic [DATA_W*PACK_NUM-1:0] data_down,
  output logic [PACK_NUM-1:0]        keep_down,
  input  logic                       ready_down
);

  localparam int unsigned CNT_W = $clog2(PACK_NUM);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PACK_NUM - 1);

  logic [CNT_W-1:0]           beat_cnt;
  logic [DATA_W*PACK_NUM-1:0] acc;
  logic [DATA_W*PACK_NUM-1:0] merged;
  logic [PACK_NUM-1:0]        keep_next;
  logic                       out_free;
  logic                       closing;
  logic                       accept;
  logic                       complete;

  assign out_free     = ~valid_down | ready_down;
  assign closing      = (beat_cnt == LAST_BEAT) | last_middle;
  // Only a word-closing beat needs the output register, so only it can stall.
  assign ready_middle = out_free | ~closing;
  assign accept       = valid_middle & ready_middle;
  assign complete     = accept & closing;

  always_comb begin
    merged    = acc;
    keep_next = '0;
    for (int unsigned i = 0; i < PACK_NUM; i++) begin
      if (CNT_W'(i) == beat_cnt) merged[i*DATA_W +: DATA_W] = data_middle;
      keep_next[i] = (i <= 32'(beat_cnt));
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      acc        <= '0;
      valid_down <= 1'b0;
      data_down  <= '0;
      keep_down  <= '0;
    end else begin
      if (complete) begin
        data_down  <= merged;
        keep_down  <= keep_next;
        valid_down <= 1'b1;
        beat_cnt   <= '0;
        acc        <= '0;
      end else begin
        if (accept) begin
          acc      <= merged;
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
        if (ready_down) valid_down <= 1'b0;
      end
    end
  end

endmodule
